// File: rtl/arith_unit_seq.sv
// arith_unit_seq: signed arithmetic unit with valid/ready handshakes.
//   add/sub/mul complete in one cycle. Signed divide runs as an iterative
//   restoring divider, one quotient bit per cycle, and returns
//   {remainder, quotient}.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   Arith_Enable        low aborts any operation and forces idle
//   A, B, ALU_FUN       operands and opcode (00 add, 01 sub, 10 mul, 11 div)
//   In_Valid/In_Ready   input handshake; operands are captured on accept
//   Arith_OUT           registered signed result (OUT_WIDTH = 2*IN_WIDTH)
//   Out_Valid/Out_Ready output handshake; result held under backpressure
//   Div_Zero, Ovf       divide-by-zero and MIN/-1 quotient overflow flags
module arith_unit_seq #(
    parameter int IN_WIDTH = 16,
    localparam int OUT_WIDTH = 2 * IN_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Arith_Enable,
    input  logic [IN_WIDTH-1:0]  A,
    input  logic [IN_WIDTH-1:0]  B,
    input  logic [1:0]           ALU_FUN,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [OUT_WIDTH-1:0] Arith_OUT,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Div_Zero,
    output logic                 Ovf
);

    localparam int CNT_W = $clog2(IN_WIDTH);
    localparam logic [IN_WIDTH-1:0] MIN_VAL = {1'b1, {(IN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t state_q, state_d;

    // Divider working registers: quo_q starts as |A| and is shifted out MSB
    // first while quotient bits shift in at the LSB.
    logic [IN_WIDTH-1:0] quo_q;
    logic [IN_WIDTH-1:0] rem_q;
    logic [IN_WIDTH-1:0] dvs_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                ovf_pend_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                        accept;
    logic                        is_div;
    logic                        last_step;
    logic signed [OUT_WIDTH-1:0] a_x;
    logic signed [OUT_WIDTH-1:0] b_x;
    logic signed [OUT_WIDTH-1:0] alu_res;
    logic [IN_WIDTH:0]           shift_w;
    logic [IN_WIDTH:0]           trial_w;
    logic                        fits;
    logic [IN_WIDTH-1:0]         quo_step;
    logic [IN_WIDTH-1:0]         rem_step;

    // Magnitude as unsigned; |MIN| = 2^(IN_WIDTH-1) is representable.
    function automatic logic [IN_WIDTH-1:0] abs_u(input logic [IN_WIDTH-1:0] v);
        return v[IN_WIDTH-1] ? (~v + IN_WIDTH'(1)) : v;
    endfunction

    // Conditional two's-complement negate; wraps for MIN.
    function automatic logic [IN_WIDTH-1:0] cneg(input logic [IN_WIDTH-1:0] v,
                                                 input logic neg);
        return neg ? (~v + IN_WIDTH'(1)) : v;
    endfunction

    assign In_Ready  = RST & Arith_Enable & (state_q == S_IDLE);
    assign accept    = In_Valid & In_Ready;
    assign is_div    = (ALU_FUN == 2'b11);
    assign last_step = (cnt_q == CNT_W'(IN_WIDTH - 1));
    assign Out_Valid = (state_q == S_DONE);

    assign a_x = {{IN_WIDTH{A[IN_WIDTH-1]}}, A};
    assign b_x = {{IN_WIDTH{B[IN_WIDTH-1]}}, B};

    always_comb begin
        alu_res = '0;
        case (ALU_FUN)
            2'b00:   alu_res = a_x + b_x;
            2'b01:   alu_res = a_x - b_x;
            default: alu_res = a_x * b_x;
        endcase
    end

    // One restoring step: the partial remainder stays below the divisor, so
    // the shifted value fits IN_WIDTH+1 bits and the trial MSB is the borrow.
    always_comb begin
        shift_w  = {rem_q, quo_q[IN_WIDTH-1]};
        trial_w  = shift_w - {1'b0, dvs_q};
        fits     = ~trial_w[IN_WIDTH];
        rem_step = fits ? trial_w[IN_WIDTH-1:0] : shift_w[IN_WIDTH-1:0];
        quo_step = {quo_q[IN_WIDTH-2:0], fits};
    end

    always_comb begin
        state_d = state_q;
        if (!Arith_Enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = (is_div && B != '0) ? S_DIV : S_DONE;
                S_DIV:  if (last_step) state_d = S_DONE;
                S_DONE: if (Out_Ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Arith_OUT  <= '0;
            Div_Zero   <= 1'b0;
            Ovf        <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            cnt_q      <= '0;
        end else if (!Arith_Enable) begin
            // Abort: discard any in-flight or unconsumed result.
            Arith_OUT <= '0;
            Div_Zero  <= 1'b0;
            Ovf       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        Div_Zero <= 1'b0;
                        Ovf      <= 1'b0;
                        if (!is_div) begin
                            Arith_OUT <= alu_res;
                        end else if (B == '0) begin
                            Arith_OUT <= '0;
                            Div_Zero  <= 1'b1;
                        end else begin
                            quo_q      <= abs_u(A);
                            dvs_q      <= abs_u(B);
                            rem_q      <= '0;
                            neg_quo_q  <= A[IN_WIDTH-1] ^ B[IN_WIDTH-1];
                            neg_rem_q  <= A[IN_WIDTH-1];
                            ovf_pend_q <= (A == MIN_VAL) && (B == '1);
                            cnt_q      <= '0;
                        end
                    end
                end
                S_DIV: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The last step's result goes straight to the output so
                    // Out_Valid rises IN_WIDTH+1 cycles after accept.
                    if (last_step) begin
                        Arith_OUT <= {cneg(rem_step, neg_rem_q), cneg(quo_step, neg_quo_q)};
                        Ovf       <= ovf_pend_q;
                    end
                end
                S_DONE: begin
                    if (Out_Ready) begin
                        Div_Zero <= 1'b0;
                        Ovf      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_unit_seq.sv
module tb_arith_unit_seq;

    localparam int W = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic            Arith_Enable;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [1:0]      ALU_FUN;
    logic            In_Valid;
    logic            In_Ready;
    logic [2*W-1:0]  Arith_OUT;
    logic            Out_Valid;
    logic            Out_Ready;
    logic            Div_Zero;
    logic            Ovf;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_out;

    arith_unit_seq #(.IN_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Arith_Enable(Arith_Enable),
        .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Arith_OUT(Arith_OUT), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Div_Zero(Div_Zero), .Ovf(Ovf)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Operand source biased toward the interesting boundary values.
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'(int'($urandom_range(0, 8)) - 4);
            default: return 16'($urandom);
        endcase
    endfunction

    // Issue one operation (called at a negedge) and check it end to end
    // against plain integer arithmetic.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        int ia, ib, q, r, lat, elat;
        logic [2*W-1:0] eo;
        logic edz, eov;
        ia = int'($signed(a));
        ib = int'($signed(b));
        edz = 1'b0; eov = 1'b0; elat = 1;
        case (op)
            2'b00: eo = 32'(ia + ib);
            2'b01: eo = 32'(ia - ib);
            2'b10: eo = 32'(ia * ib);
            default: begin
                if (ib == 0) begin
                    eo = '0; edz = 1'b1;
                end else begin
                    q = ia / ib;
                    r = ia % ib;
                    eo = {16'(r), 16'(q)};
                    eov = (ia == -32768) && (ib == -1);
                    elat = W + 1;
                end
            end
        endcase

        A = a; B = b; ALU_FUN = op; In_Valid = 1'b1;
        #1;
        chk("in_ready", In_Ready, 1);
        @(negedge CLK);
        In_Valid = 1'b0; A = 16'($urandom); B = 16'($urandom); ALU_FUN = 2'($urandom);
        lat = 1;
        while (!Out_Valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", lat, elat);
        chk("out", Arith_OUT, eo);
        chk("div_zero", Div_Zero, edz);
        chk("ovf", Ovf, eov);
        repeat (hold) begin
            In_Valid = 1'($urandom);
            tick();
            chk("hold_out", Arith_OUT, eo);
            chk("hold_vld", Out_Valid, 1);
            chk("hold_rdy", In_Ready, 0);
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        tick();
        Out_Ready = 1'b0;
        chk("post_vld", Out_Valid, 0);
        chk("post_flags", {Div_Zero, Ovf}, 0);
        chk("post_out", Arith_OUT, eo);
        last_out = eo;
    endtask

    // Start a division and stop just before cycle 8 after accept.
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a; B = b; ALU_FUN = 2'b11; In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
        repeat (7) tick();
    endtask

    task automatic no_valid_for(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            tick();
            if (Out_Valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        RST = 1'b0; Arith_Enable = 1'b1; A = '0; B = '0; ALU_FUN = '0;
        In_Valid = 1'b0; Out_Ready = 1'b0; last_out = '0;
        #1;
        chk("rst_in_ready", In_Ready, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        tick();
        chk("idle_out", Arith_OUT, 0);
        chk("idle_vld", Out_Valid, 0);
        chk("idle_flags", {Div_Zero, Ovf}, 0);
        chk("idle_rdy", In_Ready, 1);

        run_op(2'b00, 16'hFFFB, 16'd3, 0);
        chk("add_vec", last_out, 32'hFFFF_FFFE);
        run_op(2'b10, 16'(-300), 16'd200, 0);
        chk("mul_vec", last_out, 32'hFFFF_15A0);
        run_op(2'b11, 16'(-7), 16'd2, 0);
        chk("div_vec", last_out, 32'hFFFF_FFFD);
        run_op(2'b11, 16'h7FFF, 16'hFFFF, 0);
        chk("div_neg1", last_out, 32'h0000_8001);
        run_op(2'b11, 16'd100, 16'd0, 0);
        run_op(2'b11, 16'h8000, 16'hFFFF, 0);
        chk("div_ovf", last_out, 32'h0000_8000);
        run_op(2'b00, 16'd1234, 16'hF000, 5);
        run_op(2'b01, 16'h8000, 16'h7FFF, 0);

        // Abort an in-flight division with Arith_Enable.
        run_op(2'b11, 16'd100, 16'd7, 0);
        start_div(16'd1234, 16'd5);
        Arith_Enable = 1'b0;
        tick();
        chk("abort_vld", Out_Valid, 0);
        chk("abort_out", Arith_OUT, 0);
        chk("abort_rdy", In_Ready, 0);
        Arith_Enable = 1'b1;
        #1;
        chk("abort_idle", In_Ready, 1);
        no_valid_for("abort_novld", 20);

        // Reset in the middle of a division.
        run_op(2'b11, 16'hF00D, 16'd9, 0);
        start_div(16'h7123, 16'hFFF3);
        RST = 1'b0;
        #1;
        chk("rst_out", Arith_OUT, 0);
        chk("rst_vld", Out_Valid, 0);
        chk("rst_rdy", In_Ready, 0);
        chk("rst_flags", {Div_Zero, Ovf}, 0);
        @(negedge CLK);
        RST = 1'b1;
        no_valid_for("rst_novld", 20);

        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom), pick(), pick(), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
Parametrised signed arithmetic unit and successor to the single-cycle arithmetic block. It supports add, sub and mul with 1-cycle latency, and signed divide as an iterative multi-cycle restoring divider. Division returns both quotient and remainder, and flags divide-by-zero and overflow. It uses valid/ready handshakes on input and output, so it sits in the ALU datapath behind the operand registers and supports backpressure from the consumer.

Parameters:
IN_WIDTH, 16, operand width in bits (two's complement); must be >= 4.
OUT_WIDTH, 2*IN_WIDTH, result width; fixed at 2*IN_WIDTH, not overridable independently.

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-low reset
Arith_Enable  input  1  block enable; low aborts any operation and forces idle
A  input  IN_WIDTH  signed operand / dividend
B  input  IN_WIDTH  signed operand / divisor
ALU_FUN  input  2  00 add, 01 sub, 10 mul, 11 div
In_Valid  input  1  A/B/ALU_FUN valid
In_Ready  output  1  block can accept an operation this cycle
Arith_OUT  output  OUT_WIDTH  signed result (registered)
Out_Valid  output  1  Arith_OUT and flags valid
Out_Ready  input  1  consumer accepts result
Div_Zero  output  1  divide by zero on current result
Ovf  output  1  quotient overflow (MIN / -1) on current result

Behaviour:
- Reset (RST low, async): state IDLE; Arith_OUT=0, Out_Valid=0, Div_Zero=0, Ovf=0, iteration counter=0. In_Ready=0 while RST low.
- States:
  - IDLE: In_Ready = Arith_Enable.
  - DIV: iterating; In_Ready=0.
  - DONE: Out_Valid=1; In_Ready=0.
- Accept = In_Valid & In_Ready. Operands and ALU_FUN are captured only on accept; input changes afterwards are ignored.
- Add/sub/mul on accept:
  - A and B are sign-extended to OUT_WIDTH; result is registered; next state DONE.
  - Out_Valid rises the cycle after accept (latency 1).
  - No overflow is possible at OUT_WIDTH; Ovf=0, Div_Zero=0.
- Div on accept:
  - If B==0: Arith_OUT=0, Div_Zero=1, Ovf=0; next state DONE (latency 1).
  - Else: latch |A|, |B| as IN_WIDTH-bit unsigned (|MIN| = 2^(IN_WIDTH-1) fits), latch result signs, counter=0; next state DIV.
- DIV state:
  - One restoring shift-subtract step per cycle; exactly IN_WIDTH cycles, then DONE.
  - Out_Valid rises IN_WIDTH+1 cycles after accept (17 at default).
  - Quotient truncates toward zero: negated if sign(A)!=sign(B).
  - Remainder takes the sign of A.
  - Arith_OUT = {remainder[IN_WIDTH-1:0], quotient[IN_WIDTH-1:0]}.
- Overflow: A = MIN and B = -1 gives quotient = MIN (wrapped), remainder 0, Ovf=1. It still takes the full IN_WIDTH-cycle latency.
- DONE:
  - Arith_OUT and flags are held stable while Out_Valid & !Out_Ready.
  - On Out_Ready: next state IDLE; Out_Valid, Div_Zero and Ovf clear; Arith_OUT holds its last value.
  - No accept occurs in the same cycle as output handoff; maximum throughput is one op per 2 cycles (add/sub/mul).
- Arith_Enable low in any state: next cycle IDLE, Out_Valid=0, flags=0, Arith_OUT=0. This aborts an in-flight division and discards any unconsumed result.
- Reset asserted mid-DIV: immediate return to reset values. No partial result is ever presented.
- Unused/undefined cases: none; all four ALU_FUN codes are defined.

Test Plan:
- Reset then idle, Arith_Enable=1 -> Arith_OUT=0, Out_Valid=0, Div_Zero=0, Ovf=0, In_Ready=1.
- Add A=-5 (0xFFFB), B=3, accept at t -> Out_Valid at t+1, Arith_OUT=0xFFFFFFFE. Mul A=-300, B=200 -> 0xFFFF15A0 at t+1.
- Div A=-7, B=2 -> Out_Valid at t+17, Arith_OUT=0xFFFFFFFD (rem -1, quo -3), flags 0. Div A=32767, B=-1 -> quo 0x8001, rem 0.
- Div A=100, B=0 -> t+1: Div_Zero=1, Arith_OUT=0. Div A=0x8000, B=0xFFFF -> t+17: Ovf=1, Arith_OUT=0x00008000.
- Backpressure: Out_Ready=0 for 5 cycles after an add -> Out_Valid and Arith_OUT held constant, In_Ready=0, new In_Valid ignored. Out_Ready=1 -> IDLE next cycle, then accept.
- Abort: start div, drop Arith_Enable at cycle 8 -> IDLE next cycle, no Out_Valid. Repeat with RST pulsed low at cycle 8 -> all outputs 0 immediately.
